alu_result_serializer: RTL and testbench
========================================

// Module: alu_result_serializer
// PURPOSE
//  Downstream stage of the 4-bit ALU. Captures each ALU result word {odd_parity, carry_borrow, alu_out[3:0]}.
//  Buffers it in a small FIFO and shifts it out on a single pin as a UART-style frame.
//  Lets a tester or host read results one pin at a time.
//  Lets the ALU produce results faster than the serial link drains them.
// PARAMETERS
//  DEPTH    4  FIFO entries; power of 2, >=2
//  BIT_DIV  8  clk cycles per serial bit; >=2
// PORTS
//  clk         in   1  clock
//  rst_n       in   1  reset, asynchronous, active-low
//  ena         in   1  global enable; 0 freezes all state
//  in_valid    in   1  ALU word valid this cycle
//  in_result   in   4  ALU result
//  in_carry    in   1  ALU carry/borrow flag
//  in_parity   in   1  ALU odd-parity flag
//  in_ready    out  1  word accepted when in_valid&&in_ready
//  tx_serial   out  1  serial line, idle high
//  tx_busy     out  1  frame in progress
//  fifo_empty  out  1  no words buffered
//  fifo_full   out  1  DEPTH words buffered
//  overflow    out  1  sticky: a word was dropped
// BEHAVIOUR
//  Reset values (async, rst_n low):
//   - tx_serial=1, tx_busy=0, in_ready=0, fifo_empty=1, fifo_full=0, overflow=0.
//   - FSM=IDLE, FIFO pointers and count=0.
//   - Reset mid-frame aborts the frame; the line returns high immediately.
//  in_ready = ena && !fifo_full, registered from count; no same-cycle push-through when full.
//  Push: on the edge where in_valid&&in_ready, the word {parity,carry,result} is written at the tail.
//  Overflow: in_valid && ena && fifo_full sets overflow; the word is dropped.
//   - overflow is cleared only by reset.
//  ena=0: no push, no pop, baud counter and FSM hold, tx_serial holds its current level.
//   - in_valid is ignored and overflow is not set.
//  FSM states and transitions:
//   - IDLE: if !fifo_empty, pop the head into a 6-bit shift reg, load the baud counter with BIT_DIV-1, go to START.
//   - START: tx_serial=0 for BIT_DIV cycles, then go to DATA.
//   - DATA: 6 bits, LSB first: result[0..3], carry, parity. BIT_DIV cycles each; a 3-bit counter selects the bit.
//   - PAR (only if macro set): even frame-parity bit for BIT_DIV cycles.
//   - STOP: tx_serial=1 for BIT_DIV cycles, then go to IDLE.
//  Baud counter: counts down from BIT_DIV-1 to 0; at 0 it reloads and the FSM advances.
//  tx_busy=1 in START/DATA/PAR/STOP.
//  Latency:
//   - A push on edge N into an empty, idle block causes the tx_serial falling edge after edge N+2.
//   - Back-to-back frames: exactly one IDLE cycle (line high) between STOP end and the next START.
//  Frame length: 8*BIT_DIV cycles (9*BIT_DIV with parity).
//  Simultaneous push and pop: allowed when not full; count is unchanged, and the pointers wrap modulo DEPTH.
//  The pop and the in_ready=0 decision use the same registered full flag.
// CONFIGURATION
//  ALU_SER_FRAME_PARITY_EN defined:
//   - PAR state is inserted after DATA.
//   - The bit value is the XOR of the 6 data bits, giving even parity over data+PAR.
//  Undefined: PAR state and its logic are absent; the frame is start + 6 data + stop.
// STRUCTURE
//  Package alu_ser_pkg:
//   - state enum (IDLE, START, DATA, PAR, STOP).
//   - WORD_W=6, DATA_BITS=6.
//   - IDLE_LEVEL=1'b1.
//  Sub-module alu_ser_fifo: synchronous DEPTH x WORD_W FIFO with push/pop, full/empty and count.
//  FSM, baud counter and shift register stay in the top.
// TESTING
//  1. Reset: rst_n low -> tx_serial=1, tx_busy=0, fifo_empty=1, overflow=0. Release -> in_ready=1 next cycle with ena=1.
//  2. Single frame, BIT_DIV=4: push result=4'hA, carry=1, parity=0.
//     -> line sequence at 4-cycle bits is 0 | 0,1,0,1,1,0 | 1; tx_busy high for 32 cycles.
//  3. Parity build: same word as test 2 -> PAR bit=1 inserted before stop; frame is 36 cycles.
//  4. Fill/overflow, DEPTH=4: 6 consecutive pushes while the first frame runs.
//     -> the first word is popped, 4 buffered, fifo_full=1, the 6th is dropped, overflow=1 sticky.
//     -> the 5 accepted words emerge in order.
//  5. ena=0 mid DATA for 10 cycles -> line level and bit timing frozen; the frame resumes intact after ena=1.
//  6. Reset mid-frame -> tx_serial=1 immediately, FIFO empty, no residual frame after release.

Source files
------------

// File: rtl/alu_ser_pkg.sv
// ----------------------------------------------------------------------------
// alu_ser_pkg
//   Shared types and constants for the ALU result serializer.
//   - state_t      : serializer FSM states
//   - WORD_W       : width of a buffered ALU word {parity, carry, result[3:0]}
//   - DATA_BITS    : number of data bits shifted out per frame
//   - IDLE_LEVEL   : level of the serial line when no frame is in progress
//   - word_parity  : XOR reduction used for the optional frame-parity bit
// ----------------------------------------------------------------------------
package alu_ser_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   localparam int   WORD_W     = 6;
   localparam int   DATA_BITS  = 6;
   localparam logic IDLE_LEVEL = 1'b1;

   // XOR of all data bits; sending it after the data gives even parity
   // over data + parity bit.
   function automatic logic word_parity(input logic [WORD_W-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// ----------------------------------------------------------------------------
// alu_ser_fifo
//   Synchronous DEPTH x WORD_W FIFO holding ALU result words until the
//   serializer can send them.
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset (pointers and count only)
//     push_i   in   write wdata_i at the tail (ignored when full)
//     pop_i    in   drop the head entry (ignored when empty)
//     wdata_i  in   word to write
//     rdata_o  out  current head entry
//     full_o   out  DEPTH entries held
//     empty_o  out  no entries held
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module alu_ser_fifo
   import alu_ser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   // Head is read asynchronously: the FSM must load the shift register on
   // the same edge it pops, and the storage is only a handful of entries.
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// ----------------------------------------------------------------------------
// alu_result_serializer
//   Buffers ALU result words {parity, carry, result[3:0]} in a small FIFO and
//   sends each one on a single pin as a UART-style frame:
//     start(0) | result[0..3], carry, parity | [frame parity] | stop(1)
//   every bit lasting BIT_DIV clock cycles.
//   Optional feature macro: ALU_SER_FRAME_PARITY_EN inserts an even
//   frame-parity bit between the data bits and the stop bit.
//   Ports:
//     clk         in   clock
//     rst_n       in   asynchronous active-low reset
//     ena         in   global enable; 0 freezes all state
//     in_valid    in   ALU word valid this cycle
//     in_result   in   ALU result [3:0]
//     in_carry    in   ALU carry/borrow flag
//     in_parity   in   ALU odd-parity flag
//     in_ready    out  word accepted when in_valid && in_ready
//     tx_serial   out  serial line, idle high (registered)
//     tx_busy     out  frame in progress
//     fifo_empty  out  no words buffered
//     fifo_full   out  DEPTH words buffered
//     overflow    out  sticky: a word was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module alu_result_serializer
   import alu_ser_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int BIT_DIV = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       in_valid,
   input  logic [3:0] in_result,
   input  logic       in_carry,
   input  logic       in_parity,
   output logic       in_ready,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int             BW        = $clog2(BIT_DIV);
   localparam logic [BW-1:0]  BAUD_LOAD = BW'(BIT_DIV - 1);
   localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

   state_t            state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q;
   logic              init_q;
   logic              push, pop;
   logic              line_level;
   logic [WORD_W-1:0] fifo_rdata;
`ifdef ALU_SER_FRAME_PARITY_EN
   logic              par_q, par_d;
`endif

   // init_q holds in_ready low for the first cycle after reset release.
   assign in_ready  = ena && init_q && !fifo_full;
   assign push      = in_valid && in_ready;
   assign tx_serial = tx_q;
   assign tx_busy   = (state_q != IDLE);
   assign overflow  = ovf_q;

   alu_ser_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({in_parity, in_carry, in_result}),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state logic. Every non-idle state lasts BIT_DIV cycles: the baud
   // counter runs BIT_DIV-1 down to 0 and the FSM advances on 0.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef ALU_SER_FRAME_PARITY_EN
      par_d   = par_q;
`endif
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  baud_d  = BAUD_LOAD;
                  bit_d   = 3'd0;
`ifdef ALU_SER_FRAME_PARITY_EN
                  par_d   = word_parity(fifo_rdata);
`endif
                  state_d = START;
               end
            end
            START: begin
               if (baud_q == '0) begin
                  baud_d  = BAUD_LOAD;
                  state_d = DATA;
               end else begin
                  baud_d = baud_q - BW'(1);
               end
            end
            DATA: begin
               if (baud_q == '0) begin
                  baud_d  = BAUD_LOAD;
                  shift_d = shift_q >> 1;
                  if (bit_q == LAST_BIT) begin
`ifdef ALU_SER_FRAME_PARITY_EN
                     state_d = PAR;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  baud_d = baud_q - BW'(1);
               end
            end
`ifdef ALU_SER_FRAME_PARITY_EN
            PAR: begin
               if (baud_q == '0) begin
                  baud_d  = BAUD_LOAD;
                  state_d = STOP;
               end else begin
                  baud_d = baud_q - BW'(1);
               end
            end
`endif
            STOP: begin
               if (baud_q == '0) begin
                  baud_d  = BAUD_LOAD;
                  state_d = IDLE;
               end else begin
                  baud_d = baud_q - BW'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Line level for the current state. It is registered into tx_q, so the
   // pin follows the FSM one cycle later and never glitches.
   always_comb begin
      line_level = IDLE_LEVEL;
      case (state_q)
         START:   line_level = 1'b0;
         DATA:    line_level = shift_q[0];
`ifdef ALU_SER_FRAME_PARITY_EN
         PAR:     line_level = par_q;
`endif
         default: line_level = IDLE_LEVEL;
      endcase
      tx_d = ena ? line_level : tx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         tx_q    <= IDLE_LEVEL;
         ovf_q   <= 1'b0;
         init_q  <= 1'b0;
`ifdef ALU_SER_FRAME_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         init_q <= 1'b1;
         tx_q   <= tx_d;
         if (ena) begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef ALU_SER_FRAME_PARITY_EN
            par_q   <= par_d;
`endif
            if (in_valid && fifo_full) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

   localparam int BD  = 4;
   localparam int DEP = 4;
`ifdef ALU_SER_FRAME_PARITY_EN
   localparam int NB  = 9;
`else
   localparam int NB  = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_result = 4'h0;
   logic       in_carry = 1'b0;
   logic       in_parity = 1'b0;
   logic       in_ready, tx_serial, tx_busy, fifo_empty, fifo_full, overflow;

   always #5 clk = ~clk;

   alu_result_serializer #(
      .DEPTH   (DEP),
      .BIT_DIV (BD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_valid   (in_valid),
      .in_result  (in_result),
      .in_carry   (in_carry),
      .in_parity  (in_parity),
      .in_ready   (in_ready),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Serial bits of one frame in transmit order: bit 0 = start.
   function automatic logic [8:0] frame_bits(input logic [5:0] ser, input logic par);
      logic [8:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[6:1] = ser;
`ifdef ALU_SER_FRAME_PARITY_EN
      f[7]   = par;
`else
      if (par === 1'bx) f[7] = 1'b1;
`endif
      return f;
   endfunction

   // Expected {busy, line} at sample j, where sample 0 follows the push edge.
   function automatic logic [1:0] norm_at(input int j, input logic [8:0] fb);
      int   k;
      logic b, t;
      if (j == 0) return 2'b01;
      k = j - 1;
      b = (k < NB * BD);
      if (k == 0)                t = 1'b1;
      else if (k - 1 < NB * BD)  t = fb[(k - 1) / BD];
      else                       t = 1'b1;
      return {b, t};
   endfunction

   function automatic bit frame_ok(input logic [8:0] b);
      bit ok;
      ok = (b[0] == 1'b0) && (b[NB-1] == 1'b1);
`ifdef ALU_SER_FRAME_PARITY_EN
      ok = ok && (b[7] == ^b[6:1]);
`endif
      return ok;
   endfunction

   // Line decoder: samples each bit in its middle.
   logic       mon_en = 1'b0;
   logic [5:0] rx_q[$];
   bit         rx_ok_q[$];

   initial begin : monitor
      logic [8:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && tx_serial === 1'b0) begin
            b = '1;
            repeat (BD / 2) @(negedge clk);
            b[0] = tx_serial;
            for (int j = 1; j < NB; j++) begin
               repeat (BD) @(negedge clk);
               b[j] = tx_serial;
            end
            rx_q.push_back(b[6:1]);
            rx_ok_q.push_back(frame_ok(b));
         end
      end
   end

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (!(tx_busy === 1'b0 && fifo_empty === 1'b1) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk1("idle timeout", n >= max, 1'b0);
      @(negedge clk);
   endtask

   task automatic wait_rx(input int want, input int max);
      int n;
      n = 0;
      while (rx_q.size() < want && n < max) begin
         @(negedge clk);
         n++;
      end
      chk1("rx timeout", n >= max, 1'b0);
   endtask

   // Pushes one word and records line/busy for the whole frame; optionally
   // drops ena for 10 cycles right after sample fr_at.
   task automatic run_frame(input string name, input logic [3:0] r, input logic c,
                            input logic p, input logic [8:0] fb, input int fr_at);
      logic [63:0] at, et, ab, eb;
      logic [1:0]  e;
      int          len, jj;
      at = '0; et = '0; ab = '0; eb = '0;
      len = NB * BD + 2 + ((fr_at >= 0) ? 10 : 0);
      @(negedge clk);
      in_valid = 1'b1; in_result = r; in_carry = c; in_parity = p;
      for (int j = 0; j < len; j++) begin
         @(negedge clk);
         if (j == 0) in_valid = 1'b0;
         at[j] = tx_serial;
         ab[j] = tx_busy;
         if (fr_at >= 0 && j > fr_at && j <= fr_at + 10) jj = fr_at;
         else if (fr_at >= 0 && j > fr_at + 10)          jj = j - 10;
         else                                            jj = j;
         e = norm_at(jj, fb);
         et[j] = e[0];
         eb[j] = e[1];
         if (fr_at >= 0 && j == fr_at + 1) chk1({name, " in_ready frozen"}, in_ready, 1'b0);
         if (fr_at >= 0 && j == fr_at)      ena = 1'b0;
         if (fr_at >= 0 && j == fr_at + 10) ena = 1'b1;
      end
      chkv({name, " line"}, at, et);
      chkv({name, " busy"}, ab, eb);
      $display("frame %s word=%h%h%h line=%0h", name, p, c, r, at);
   endtask

   typedef struct {
      logic [3:0] r;
      logic       c;
      logic       p;
      logic [5:0] ser;
      logic       par;
   } vec_t;

   initial begin : main
      vec_t       tbl[4];
      logic [5:0] w[6];
      logic [5:0] exp_q[$];
      logic [5:0] rw;
      int         blen, lows;

      tbl[0] = '{4'hA, 1'b1, 1'b0, 6'b011010, 1'b1};
      tbl[1] = '{4'h0, 1'b0, 1'b0, 6'b000000, 1'b0};
      tbl[2] = '{4'hF, 1'b1, 1'b1, 6'b111111, 1'b0};
      tbl[3] = '{4'h5, 1'b0, 1'b1, 6'b100101, 1'b1};

      // Reset state
      ena = 1'b1;
      repeat (3) @(negedge clk);
      chk1("rst tx_serial", tx_serial, 1'b1);
      chk1("rst tx_busy", tx_busy, 1'b0);
      chk1("rst fifo_empty", fifo_empty, 1'b1);
      chk1("rst fifo_full", fifo_full, 1'b0);
      chk1("rst overflow", overflow, 1'b0);
      chk1("rst in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("in_ready after release", in_ready, 1'b1);

      // Table-driven single frames with exact timing
      for (int i = 0; i < 4; i++) begin
         wait_idle(200);
         run_frame($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].p,
                   frame_bits(tbl[i].ser, tbl[i].par), -1);
      end

      // ena low for 10 cycles inside DATA bit 1
      wait_idle(200);
      run_frame("freeze", tbl[0].r, tbl[0].c, tbl[0].p, frame_bits(tbl[0].ser, tbl[0].par), 10);

      // Fill and overflow
      wait_idle(200);
      rx_q.delete(); rx_ok_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) w[i] = 6'($urandom);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk1($sformatf("fill in_ready %0d", i), in_ready, (i < 5) ? 1'b1 : 1'b0);
         in_valid = 1'b1;
         {in_parity, in_carry, in_result} = w[i];
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk1("fill fifo_full", fifo_full, 1'b1);
      chk1("fill overflow", overflow, 1'b1);
      wait_rx(5, 600);
      repeat (2 * NB * BD) @(negedge clk);
      chkv("fill rx count", 64'(rx_q.size()), 64'd5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
         chkv($sformatf("fill word %0d", i), 64'(rx_q[i]), 64'(w[i]));
         chk1($sformatf("fill framing %0d", i), rx_ok_q[i], 1'b1);
         $display("fill word %0d rx=%h exp=%h", i, rx_q[i], w[i]);
      end
      chk1("overflow sticky", overflow, 1'b1);
      chk1("fill drained", fifo_empty, 1'b1);

      // Randomized bursts against a queue model
      rx_q.delete(); rx_ok_q.delete();
      for (int b = 0; b < 12; b++) begin
         blen = $urandom_range(1, 3);
         for (int i = 0; i < blen; i++) begin
            @(negedge clk);
            chk1($sformatf("rand in_ready b%0d", b), in_ready, 1'b1);
            rw = 6'($urandom);
            in_valid = 1'b1;
            {in_parity, in_carry, in_result} = rw;
            exp_q.push_back(rw);
         end
         @(negedge clk);
         in_valid = 1'b0;
         wait_rx(exp_q.size(), 400);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      chkv("rand rx count", 64'(rx_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chkv($sformatf("rand word %0d", i), 64'(rx_q[i]), 64'(exp_q[i]));
         chk1($sformatf("rand framing %0d", i), rx_ok_q[i], 1'b1);
         $display("rand word %0d rx=%h exp=%h", i, rx_q[i], exp_q[i]);
      end

      // Reset in the middle of a frame
      mon_en = 1'b0;
      wait_idle(200);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         {in_parity, in_carry, in_result} = 6'(6'h11 * (i + 1));
      end
      @(negedge clk);
      in_valid = 1'b0;
      lows = 0;
      while (tx_serial !== 1'b0 && lows < 20) begin
         @(negedge clk);
         lows++;
      end
      chk1("midrst line low before", tx_serial, 1'b0);
      chk1("midrst fifo holds words", fifo_empty, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk1("midrst tx_serial", tx_serial, 1'b1);
      chk1("midrst tx_busy", tx_busy, 1'b0);
      chk1("midrst fifo_empty", fifo_empty, 1'b1);
      chk1("midrst overflow cleared", overflow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete(); rx_ok_q.delete();
      mon_en = 1'b1;
      lows = 0;
      for (int i = 0; i < 3 * NB * BD; i++) begin
         @(negedge clk);
         if (tx_serial !== 1'b1) lows++;
      end
      chkv("post-reset line low samples", 64'(lows), 64'd0);
      chkv("post-reset rx count", 64'(rx_q.size()), 64'd0);
      chk1("post-reset tx_busy", tx_busy, 1'b0);
      chk1("post-reset fifo_empty", fifo_empty, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
